// File: rtl/load_store_controller.sv
// rtl/load_store_controller.sv - data-memory load/store sequencer with byte-lane formatting (optional watchdog: LSU_TIMEOUT_EN)
module load_store_controller #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic              valid,
    output logic              load_signal_controller,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign,
    output logic              err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              err_q, err_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic              req_in;
    logic              misaligned_in;
    logic              idle, busy, done;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] ext_data;
    logic [3:0]        be_busy;
    logic [DATA_W-1:0] wdata_rep;

    assign idle = (state_q == IDLE);
    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);

    // Incoming request decode; size is funct3[1:0] (00 byte, 01 half, else word)
    always_comb begin
        req_in        = load | store;
        misaligned_in = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        (funct3[1] && (addr[1:0] != 2'b00));
    end

    // Load-data lane select and sign/zero extension from the latched access
    always_comb begin
        lane = mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  ext_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext_data = {24'd0, lane[7:0]};
            3'b101:  ext_data = {16'd0, lane[15:0]};
            default: ext_data = mem_rdata;
        endcase
    end

    // Byte enables and store-data replication for the latched access
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                be_busy   = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_busy   = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be_busy   = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    // Next-state logic: IDLE -> BUSY on an aligned request, BUSY -> DONE on ack (or watchdog), DONE -> IDLE
    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        err_d      = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_in) begin
                    if (misaligned_in) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d   = BUSY;
                        is_load_d = load;
                        funct3_d  = funct3;
                        addr_d    = addr;
                        wdata_d   = wdata;
`ifdef LSU_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = DONE;
                    if (is_load_q) begin
                        rdata_d = ext_data;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (is_load_q) begin
                        rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            is_load_q  <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Outputs: memory side is only driven while BUSY, so IDLE/DONE present all zeros
    always_comb begin
        mem_req                = busy;
        mem_we                 = busy & ~is_load_q;
        mem_be                 = busy ? be_busy : 4'd0;
        mem_addr               = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata              = busy ? wdata_rep : '0;
        stall                  = (idle & req_in & ~misaligned_in) | busy;
        valid                  = done & is_load_q;
        load_signal_controller = (busy | done) & is_load_q;
        rdata                  = rdata_q;
        misalign               = misalign_q;
`ifdef LSU_TIMEOUT_EN
        err                    = err_q;
`else
        err                    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_load_store_controller.sv
// tb/tb_load_store_controller.sv - scoreboard bench for load_store_controller
module tb_load_store_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, valid, load_signal_controller;
    logic [31:0] rdata;
    logic        misalign, err;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] sb[$];

    load_store_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .stall(stall), .valid(valid),
        .load_signal_controller(load_signal_controller), .rdata(rdata),
        .misalign(misalign), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest expected {rdata, err}
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("sb_rdata", rdata, e[32:1]);
                check("sb_err", {31'd0, err}, {31'd0, e[0]});
            end
        end
    end

    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int lat, input logic [31:0] exp_rdata,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int req_cnt;
        int stall_cnt;
        req_cnt   = 0;
        stall_cnt = 0;
        @(negedge clk);
        load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
        #1;
        if (stall) stall_cnt++;
        if (ld) sb.push_back({exp_rdata, 1'b0});
        @(negedge clk);
        load = 1'b0; store = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k == 1) begin
                check("busy_be", {28'd0, mem_be}, {28'd0, exp_be});
                check("busy_we", {31'd0, mem_we}, {31'd0, ~ld});
                check("busy_addr", mem_addr, {a[31:2], 2'b00});
                check("busy_lsc", {31'd0, load_signal_controller}, {31'd0, ld});
                if (!ld) check("busy_wdata", mem_wdata, exp_wdata);
            end
            if (mem_req) req_cnt++;
            if (stall) stall_cnt++;
            if (k == lat) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("done_req", {31'd0, mem_req}, 32'd0);
        check("done_stall", {31'd0, stall}, 32'd0);
        check("done_valid", {31'd0, valid}, {31'd0, ld});
        check("done_lsc", {31'd0, load_signal_controller}, {31'd0, ld});
        check("req_cycles", req_cnt, lat);
        check("stall_cycles", stall_cnt, lat + 1);
        @(negedge clk);
        check("idle_req", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; store = 1'b0; funct3 = 3'd0; addr = 32'd0;
        wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);

        // LW with 3-cycle ack latency
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 4'b1111, 32'h0);
        check("rdata_hold", rdata, 32'hDEADBEEF);
        // LB / LBU top lane
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80000000, 1, 32'hFFFFFF80, 4'b1000, 32'h0);
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80000000, 2, 32'h00000080, 4'b1000, 32'h0);
        // LH / LHU upper half, sign bit set
        run_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h9ABC1234, 1, 32'hFFFF9ABC, 4'b1100, 32'h0);
        run_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h9ABC1234, 1, 32'h00009ABC, 4'b1100, 32'h0);
        run_access(1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 2, 32'h0000007F, 4'b0010, 32'h0);
        // SH, SB, SW
        run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2, 32'h0, 4'b1100, 32'hABCDABCD);
        check("store_keeps_rdata", rdata, 32'h0000007F);
        run_access(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 1, 32'h0, 4'b0010, 32'hA5A5A5A5);
        run_access(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 4, 32'h0, 4'b1111, 32'hCAFEF00D);
        // load and store together: load wins
        run_access(1, 1, 3'b010, 32'h108, 32'h55555555, 32'h13579BDF, 1, 32'h13579BDF, 4'b1111, 32'h0);

        // misaligned LW and LH
        @(negedge clk);
        load = 1'b1; funct3 = 3'b010; addr = 32'h101;
        #1 check("mis_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        load = 1'b0;
        check("mis_pulse", {31'd0, misalign}, 32'd1);
        check("mis_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("mis_pulse_end", {31'd0, misalign}, 32'd0);
        check("mis_req2", {31'd0, mem_req}, 32'd0);
        load = 1'b1; funct3 = 3'b001; addr = 32'h103;
        @(negedge clk);
        load = 1'b0;
        check("mis_h_pulse", {31'd0, misalign}, 32'd1);
        check("mis_h_req", {31'd0, mem_req}, 32'd0);

        // reset mid-BUSY, then a late ack
        @(negedge clk);
        load = 1'b1; funct3 = 3'b010; addr = 32'h120;
        @(negedge clk);
        load = 1'b0;
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_req", {31'd0, mem_req}, 32'd0);
        check("post_rst_stall", {31'd0, stall}, 32'd0);
        check("post_rst_lsc", {31'd0, load_signal_controller}, 32'd0);
        check("post_rst_rdata", rdata, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("late_ack_valid", {31'd0, valid}, 32'd0);
        check("late_ack_rdata", rdata, 32'd0);

`ifdef LSU_TIMEOUT_EN
        begin
            int busy_cnt;
            int guard;
            busy_cnt = 0;
            guard = 0;
            @(negedge clk);
            load = 1'b1; funct3 = 3'b010; addr = 32'h300;
            sb.push_back({32'd0, 1'b1});
            @(negedge clk);
            load = 1'b0;
            while (mem_req && guard < 40) begin
                busy_cnt++;
                guard++;
                @(negedge clk);
            end
            check("to_busy_cycles", busy_cnt, 16);
            check("to_err", {31'd0, err}, 32'd1);
            @(negedge clk);
            check("to_err_end", {31'd0, err}, 32'd0);
        end
        run_access(1, 0, 3'b010, 32'h304, 32'h0, 32'h600DF00D, 16, 32'h600DF00D, 4'b1111, 32'h0);
`else
        run_access(1, 0, 3'b010, 32'h304, 32'h0, 32'h600DF00D, 20, 32'h600DF00D, 4'b1111, 32'h0);
        check("no_timeout_err", {31'd0, err}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
